// File: rtl/sobel_filter_top_if.sv
// Raster pixel stream through the Sobel edge detector.
// Carries RGB and syncs in, and edge magnitude with delayed syncs out.
interface sobel_filter_top_if #(
    parameter int COLORDEPTH = 8
);
    logic [3*COLORDEPTH-1:0] rgb_i;
    logic                    dv_i;
    logic                    hs_i;
    logic                    vs_i;
    logic [COLORDEPTH-1:0]   sobel_o;
    logic                    dv_o;
    logic                    hs_o;
    logic                    vs_o;

    modport master (output rgb_i, dv_i, hs_i, vs_i, input  sobel_o, dv_o, hs_o, vs_o);
    modport slave  (input  rgb_i, dv_i, hs_i, vs_i, output sobel_o, dv_o, hs_o, vs_o);
endinterface

// File: rtl/sobel_filter_top.sv
// Streaming Sobel edge detector: RGB -> luma -> 2 line buffers + 3x3 window -> |Gx|+|Gy|.
// Four register stages (luma, window, gradient, magnitude); syncs ride a matching shift register.
module sobel_filter_top #(
    parameter int COLORDEPTH = 8,
    parameter int POWEREFF   = 0,
    parameter int MAX_LINE   = 1024,
    parameter int VS_ACTIVE  = 0
) (
    input  logic              clk,
    input  logic              rst,
    sobel_filter_top_if.slave io
);
    localparam int CD     = COLORDEPTH;
    localparam int AW     = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;
    localparam int GW     = CD + 3;
    localparam int STAGES = 4;
    localparam logic [CD-1:0] PE_MASK = CD'((1 << POWEREFF) - 1);
    localparam logic [CD-1:0] Y_MAX   = '1;
    localparam logic          VS_ON   = 1'(VS_ACTIVE);

    typedef logic [CD-1:0] pix_t;

    logic [STAGES:1]      dv_pipe_q, dv_pipe_d;
    logic [STAGES:1]      hs_pipe_q, hs_pipe_d;
    logic [STAGES:1]      vs_pipe_q, vs_pipe_d;
    pix_t                 y_q, y_d;
    logic [AW-1:0]        col_q, col_d;
    logic [1:0]           row_q, row_d;
    pix_t [2:0][2:0]      win_q, win_d;
    logic                 bord2_q, bord2_d, bord3_q, bord3_d;
    logic signed [GW-1:0] gx_q, gx_d, gy_q, gy_d;
    pix_t                 sobel_q, sobel_d;

    pix_t                 lb0_mem [MAX_LINE];
    pix_t                 lb1_mem [MAX_LINE];
    pix_t                 lb0_rd, lb1_rd;
    pix_t                 r_in, g_in, b_in;
    logic [CD+7:0]        luma_sum;
    logic [GW-1:0]        abs_x, abs_y;
    logic [GW:0]          mag;

    function automatic logic signed [GW-1:0] ext(input pix_t p);
        return $signed({3'b000, p});
    endfunction

    assign {r_in, g_in, b_in} = io.rgb_i;
    assign lb0_rd = lb0_mem[col_q];
    assign lb1_rd = lb1_mem[col_q];

    always_comb begin
        dv_pipe_d = {dv_pipe_q[STAGES-1:1], io.dv_i};
        hs_pipe_d = {hs_pipe_q[STAGES-1:1], io.hs_i};
        vs_pipe_d = {vs_pipe_q[STAGES-1:1], io.vs_i};

        luma_sum = (CD+8)'(r_in) * (CD+8)'(77) + (CD+8)'(g_in) * (CD+8)'(150)
                 + (CD+8)'(b_in) * (CD+8)'(29);
        y_d = CD'(luma_sum >> 8) & ~PE_MASK;

        // col_q is the column of the pixel currently held in y_q
        col_d = dv_pipe_q[1] ? col_q + AW'(1) : '0;
        // Only "row < 2" matters downstream, so the row count saturates at 2
        row_d = row_q;
        if (vs_pipe_q[1] == VS_ON)
            row_d = '0;
        else if (dv_pipe_q[2] && !dv_pipe_q[1] && row_q != 2'd2)
            row_d = row_q + 2'd1;

        win_d = win_q;
        if (dv_pipe_q[1]) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = lb1_rd;
            win_d[1][2] = lb0_rd;
            win_d[2][2] = y_q;
        end
        bord2_d = (row_q < 2'd2) || (col_q < AW'(2));
        bord3_d = bord2_q;

        gx_d = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
             - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
        gy_d = (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]))
             - (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]));

        abs_x = gx_q[GW-1] ? -gx_q : gx_q;
        abs_y = gy_q[GW-1] ? -gy_q : gy_q;
        mag   = {1'b0, abs_x} + {1'b0, abs_y};
        sobel_d = '0;
        if (dv_pipe_q[3] && !bord3_q)
            sobel_d = (mag > (GW+1)'(Y_MAX)) ? Y_MAX : mag[CD-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dv_pipe_q <= '0;
            hs_pipe_q <= '0;
            vs_pipe_q <= '0;
            y_q       <= '0;
            col_q     <= '0;
            row_q     <= '0;
            win_q     <= '0;
            bord2_q   <= 1'b0;
            bord3_q   <= 1'b0;
            gx_q      <= '0;
            gy_q      <= '0;
            sobel_q   <= '0;
        end else begin
            dv_pipe_q <= dv_pipe_d;
            hs_pipe_q <= hs_pipe_d;
            vs_pipe_q <= vs_pipe_d;
            y_q       <= y_d;
            col_q     <= col_d;
            row_q     <= row_d;
            win_q     <= win_d;
            bord2_q   <= bord2_d;
            bord3_q   <= bord3_d;
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            sobel_q   <= sobel_d;
        end
    end

    // Read-before-write cascade: LB1 takes the old LB0 entry, LB0 takes the new luma
    always_ff @(posedge clk) begin
        if (dv_pipe_q[1]) begin
            lb0_mem[col_q] <= y_q;
            lb1_mem[col_q] <= lb0_rd;
        end
    end

    assign io.sobel_o = sobel_q;
    assign io.dv_o    = dv_pipe_q[STAGES];
    assign io.hs_o    = hs_pipe_q[STAGES];
    assign io.vs_o    = vs_pipe_q[STAGES];
endmodule

// File: tb/tb_sobel_filter_top.sv
// Directed bench for sobel_filter_top: short raster frames with hand-derived edge values,
// plus an LFSR frame with a mid-frame reset checked against a 2D-convolution reference.
module tb_sobel_filter_top;
    localparam int CD  = 8;
    localparam int ACT = 8;
    localparam int HBL = 4;
    localparam int P_FLAT = 0, P_VEDGE = 1, P_VINV = 2, P_HEDGE = 3, P_RAMP = 4, P_LFSR = 5;

    typedef struct {
        string       tag;
        logic [10:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sobel_filter_top_if #(.COLORDEPTH(CD)) bus ();

    sobel_filter_top #(
        .COLORDEPTH(CD), .POWEREFF(0), .MAX_LINE(1024), .VS_ACTIVE(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );

    exp_t        q[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [7:0]  img [0:15][0:ACT-1];
    logic [31:0] lfsr = 32'h1234_5678;
    int          kx [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    int          ky [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] luma(input logic [23:0] px);
        int s;
        s = 77 * int'(px[23:16]) + 150 * int'(px[15:8]) + 29 * int'(px[7:0]);
        return 8'(s >> 8);
    endfunction

    // Reference: window rows r-2..r, cols c-2..c of the stored luma image
    function automatic logic [7:0] golden(input int r, input int c);
        int gx, gy, m;
        gx = 0;
        gy = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                gx += kx[i][j] * int'(img[r-2+i][c-2+j]);
                gy += ky[i][j] * int'(img[r-2+i][c-2+j]);
            end
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 8'd255 : 8'(m);
    endfunction

    function automatic logic [7:0] expv(input int pat, input int r, input int c);
        case (pat)
            P_VEDGE, P_VINV: return (c == 4 || c == 5) ? 8'd255 : 8'd0;
            P_HEDGE:         return (r == 4 || r == 5) ? 8'd255 : 8'd0;
            P_RAMP:          return 8'd80;
            P_LFSR:          return golden(r, c);
            default:         return 8'd0;
        endcase
    endfunction

    // One clock: drive, push the expectation, then compare the output that is due now
    task automatic step(input string tag, input logic r, input logic [23:0] rgb,
                        input logic dv, input logic hs, input logic vs, input logic [7:0] es);
        exp_t e;
        logic [10:0] out;
        rst = r;
        bus.rgb_i = rgb;
        bus.dv_i = dv;
        bus.hs_i = hs;
        bus.vs_i = vs;
        e.tag = tag;
        e.v = {vs, hs, dv, dv ? es : 8'd0};
        if (!r) q.push_back(e);
        @(posedge clk);
        #1;
        out = {bus.vs_o, bus.hs_o, bus.dv_o, bus.sobel_o};
        if (r) begin
            chk({tag, "/rst"}, 32'(out), 32'd0);
            q.delete();
            e.tag = {tag, "/after_rst"};
            e.v = '0;
            for (int i = 0; i < 3; i++) q.push_back(e);
        end else if (q.size() == 4) begin
            e = q.pop_front();
            chk(e.tag, 32'(out), 32'(e.v));
        end
    endtask

    task automatic frame(input string tag, input int pat, input int rows, input int rst_line);
        int rr;
        logic [23:0] px;
        logic [7:0] v, es;
        for (int i = 0; i < 3; i++) step(tag, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 2; i++) step(tag, 1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 8'd0);
        rr = 0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < ACT; c++) begin
                case (pat)
                    P_FLAT:  px = 24'hFF0000;
                    P_VEDGE: px = (c >= 4) ? 24'hFFFFFF : 24'h0;
                    P_VINV:  px = (c < 4) ? 24'hFFFFFF : 24'h0;
                    P_HEDGE: px = (r < 4) ? 24'hFFFFFF : 24'h0;
                    P_RAMP:  begin v = 8'(10 * c); px = {v, v, v}; end
                    default: begin
                        px = lfsr[23:0];
                        lfsr = lfsr[0] ? ((lfsr >> 1) ^ 32'h8020_0003) : (lfsr >> 1);
                    end
                endcase
                img[r][c] = luma(px);
                es = (rr >= 2 && c >= 2) ? expv(pat, r, c) : 8'd0;
                step(tag, 1'b0, px, 1'b1, 1'b0, 1'b1, es);
            end
            for (int i = 0; i < HBL; i++) step(tag, 1'b0, 24'h0, 1'b0, i == 1, 1'b1, 8'd0);
            rr++;
            if (r == rst_line) begin
                for (int i = 0; i < 3; i++) step(tag, 1'b1, 24'hABCDEF, 1'b0, 1'b0, 1'b1, 8'd0);
                rr = 0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) step("reset", 1'b1, 24'h0, 1'b0, 1'b0, 1'b1, 8'd0);
        for (int i = 0; i < 4; i++) step("idle", 1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 8'd0);
        // Isolated single-cycle pulses must reappear exactly four clocks later
        step("hs_pulse", 1'b0, 24'h0, 1'b0, 1'b1, 1'b1, 8'd0);
        for (int i = 0; i < 5; i++) step("hs_gap", 1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 8'd0);
        step("vs_pulse", 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) step("vs_gap", 1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 8'd0);
        step("dv_pulse", 1'b0, 24'hFFFFFF, 1'b1, 1'b0, 1'b1, 8'd0);
        for (int i = 0; i < 5; i++) step("dv_gap", 1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 8'd0);

        frame("flat_red", P_FLAT, 8, -1);
        frame("vedge", P_VEDGE, 8, -1);
        frame("vedge_inv", P_VINV, 8, -1);
        frame("hedge", P_HEDGE, 8, -1);
        frame("ramp", P_RAMP, 8, -1);
        frame("lfsr_rst", P_LFSR, 10, 4);
        for (int i = 0; i < 6; i++) step("drain", 1'b0, 24'h0, 1'b0, 1'b0, 1'b1, 8'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end
endmodule
